// File: rtl/lsb_pkg.sv
// Shared constants and types for the load/store buffer: op classes, funct3 codes,
// queue geometry, the I/O window marker and the head-execution FSM states.
package lsb_pkg;

    localparam int         LSB_LEN = 16;
    localparam int         ROB_W   = 4;
    localparam logic [1:0] IO_HI   = 2'b11;

    localparam logic [2:0] OPC_LOAD  = 3'b101;
    localparam logic [2:0] OPC_STORE = 3'b111;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_DISCARD} state_t;

    // Memory access size code: 0 = byte, 1 = half, 2 = word.
    function automatic logic [1:0] access_len(input logic is_store, input logic [2:0] f3);
        logic [1:0] len;
        len = 2'd2;
        if (is_store) begin
            case (f3)
                F3_SB:   len = 2'd0;
                F3_SH:   len = 2'd1;
                default: len = 2'd2;
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: len = 2'd0;
                F3_LH, F3_LHU: len = 2'd1;
                default:       len = 2'd2;
            endcase
        end
        return len;
    endfunction

endpackage

// File: rtl/lsb_load_ext.sv
// Byte/half extension of memory read data; the memory controller returns the
// addressed byte or half right-aligned in rdata.
module lsb_load_ext
    import lsb_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] rdata,
    output logic [31:0] data
);

    always_comb begin
        data = rdata;
        case (funct3)
            F3_LB:   data = {{24{rdata[7]}}, rdata[7:0]};
            F3_LH:   data = {{16{rdata[15]}}, rdata[15:0]};
            F3_LW:   data = rdata;
            F3_LBU:  data = {24'b0, rdata[7:0]};
            F3_LHU:  data = {16'b0, rdata[15:0]};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/lsb.sv
// Load/store buffer: in-order circular queue of memory ops that snoops both CDBs,
// executes one op at a time from the head and keeps committed stores across clear.
module lsb #(
    parameter int         LSB_LEN = lsb_pkg::LSB_LEN,
    parameter int         ROB_W   = lsb_pkg::ROB_W,
    parameter logic [1:0] IO_HI   = lsb_pkg::IO_HI
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             clear,
    input  logic             from_dc_ok,
    input  logic [5:0]       dc_opt,
    input  logic [ROB_W-1:0] dc_Qj,
    input  logic             dc_Qj_ok,
    input  logic [31:0]      dc_Vj,
    input  logic [ROB_W-1:0] dc_Qk,
    input  logic             dc_Qk_ok,
    input  logic [31:0]      dc_Vk,
    input  logic [31:0]      dc_imm,
    input  logic [ROB_W-1:0] dc_rob_en,
    output logic             is_lsb_full,
    input  logic             rob_commit,
    input  logic [ROB_W-1:0] rob_commit_pos,
    input  logic [ROB_W-1:0] rob_head,
    input  logic             CDB_1_ok,
    input  logic [ROB_W-1:0] CDB_1_en,
    input  logic [31:0]      CDB_1_val,
    input  logic             CDB_2_ok,
    input  logic [ROB_W-1:0] CDB_2_en,
    input  logic [31:0]      CDB_2_val,
    output logic             mem_req,
    output logic             mem_wr,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    output logic [1:0]       mem_len,
    input  logic             mem_done,
    input  logic [31:0]      mem_rdata,
    output logic             lsb_out_ok,
    output logic [ROB_W-1:0] lsb_out_en,
    output logic [31:0]      lsb_out_val
);
    import lsb_pkg::*;

    localparam int IDX_W = $clog2(LSB_LEN);
    localparam int CNT_W = IDX_W + 1;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [CNT_W-1:0] cnt_t;

    typedef struct packed {
        logic [5:0]       op;
        logic [ROB_W-1:0] qj;
        logic             rj;
        logic [31:0]      vj;
        logic [ROB_W-1:0] qk;
        logic             rk;
        logic [31:0]      vk;
        logic [31:0]      imm;
        logic [ROB_W-1:0] tag;
        logic             cmt;
    } entry_t;

    entry_t             ent [LSB_LEN];
    logic [LSB_LEN-1:0] valid;
    idx_t               head, tail;
    cnt_t               count;
    state_t             state;

    entry_t             hd, new_ent;
    logic               hd_load, hd_store, pop, issue;
    logic [31:0]        hd_addr, ext_data;
    logic [LSB_LEN-1:0] commit_hit, keep_mask;
    idx_t               base;
    cnt_t               keep;

    assign hd          = ent[head];
    assign hd_load     = hd.op[5:3] == OPC_LOAD;
    assign hd_store    = hd.op[5:3] == OPC_STORE;
    assign hd_addr     = hd.vj + hd.imm;
    assign pop         = (state != ST_IDLE) && mem_done;
    assign issue       = from_dc_ok && !clear;
    assign is_lsb_full = count >= cnt_t'(LSB_LEN - 1);

    lsb_load_ext u_load_ext (
        .funct3 (hd.op[2:0]),
        .rdata  (mem_rdata),
        .data   (ext_data)
    );

    // NOTE: every always_comb output is given a default before any branch so no latch is inferred.
    always_comb begin
        commit_hit = '0;
        for (int i = 0; i < LSB_LEN; i++)
            commit_hit[i] = rob_commit && valid[i] && ent[i].op[5:3] == OPC_STORE
                            && ent[i].tag == rob_commit_pos;
    end

    // New entry, capturing an operand that is broadcast in the issue cycle itself.
    always_comb begin
        new_ent     = '0;
        new_ent.op  = dc_opt;
        new_ent.qj  = dc_Qj;
        new_ent.rj  = dc_Qj_ok;
        new_ent.vj  = dc_Vj;
        new_ent.qk  = dc_Qk;
        new_ent.rk  = dc_Qk_ok;
        new_ent.vk  = dc_Vk;
        new_ent.imm = dc_imm;
        new_ent.tag = dc_rob_en;
        if (!dc_Qj_ok) begin
            if (CDB_1_ok && CDB_1_en == dc_Qj) begin
                new_ent.rj = 1'b1;
                new_ent.vj = CDB_1_val;
            end else if (CDB_2_ok && CDB_2_en == dc_Qj) begin
                new_ent.rj = 1'b1;
                new_ent.vj = CDB_2_val;
            end
        end
        if (!dc_Qk_ok) begin
            if (CDB_1_ok && CDB_1_en == dc_Qk) begin
                new_ent.rk = 1'b1;
                new_ent.vk = CDB_1_val;
            end else if (CDB_2_ok && CDB_2_en == dc_Qk) begin
                new_ent.rk = 1'b1;
                new_ent.vk = CDB_2_val;
            end
        end
    end

    // Survivors of clear: the committed-store run after any same-cycle pop, or just
    // the in-flight load so the discard path still has an entry to pop.
    always_comb begin : keep_calc
        logic run;
        cnt_t avail;
        idx_t idx;
        base  = head + idx_t'(pop);
        avail = count - cnt_t'(pop);
        keep  = '0;
        run   = 1'b1;
        idx   = '0;
        for (int k = 0; k < LSB_LEN; k++) begin
            idx = base + idx_t'(k);
            if (run && cnt_t'(k) < avail && valid[idx] && ent[idx].op[5:3] == OPC_STORE
                && (ent[idx].cmt || commit_hit[idx]))
                keep = keep + cnt_t'(1);
            else
                run = 1'b0;
        end
        if (state != ST_IDLE && !pop && hd_load)
            keep = cnt_t'(1);
    end

    always_comb begin : mask_calc
        idx_t off;
        keep_mask = '0;
        off       = '0;
        for (int i = 0; i < LSB_LEN; i++) begin
            off          = idx_t'(i) - base;
            keep_mask[i] = {1'b0, off} < keep;
        end
    end

    // NOTE: the entry payload has no reset; valid qualifies every slot, so stale contents are never used.
    always_ff @(posedge clk) begin
        if (rdy) begin
            for (int i = 0; i < LSB_LEN; i++) begin
                if (!ent[i].rj) begin
                    if (CDB_1_ok && ent[i].qj == CDB_1_en) begin
                        ent[i].vj <= CDB_1_val;
                        ent[i].rj <= 1'b1;
                    end else if (CDB_2_ok && ent[i].qj == CDB_2_en) begin
                        ent[i].vj <= CDB_2_val;
                        ent[i].rj <= 1'b1;
                    end
                end
                if (!ent[i].rk) begin
                    if (CDB_1_ok && ent[i].qk == CDB_1_en) begin
                        ent[i].vk <= CDB_1_val;
                        ent[i].rk <= 1'b1;
                    end else if (CDB_2_ok && ent[i].qk == CDB_2_en) begin
                        ent[i].vk <= CDB_2_val;
                        ent[i].rk <= 1'b1;
                    end
                end
                if (commit_hit[i])
                    ent[i].cmt <= 1'b1;
            end
            if (issue)
                ent[tail] <= new_ent;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every read sees pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            valid       <= '0;
            state       <= ST_IDLE;
            mem_req     <= 1'b0;
            mem_wr      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_len     <= '0;
            lsb_out_ok  <= 1'b0;
            lsb_out_en  <= '0;
            lsb_out_val <= '0;
        end else if (rdy) begin
            lsb_out_ok <= 1'b0;
            if (clear) begin
                valid <= valid & keep_mask;
                head  <= base;
                tail  <= base + keep[IDX_W-1:0];
                count <= keep;
            end else begin
                if (pop)
                    valid[head] <= 1'b0;
                if (issue)
                    valid[tail] <= 1'b1;
                head  <= head + idx_t'(pop);
                tail  <= tail + idx_t'(issue);
                count <= count + cnt_t'(issue) - cnt_t'(pop);
            end

            case (state)
                ST_IDLE: begin
                    if (!clear && valid[head] && hd.rj) begin
                        if (hd_store && hd.rk && hd.cmt) begin
                            mem_req   <= 1'b1;
                            mem_wr    <= 1'b1;
                            mem_addr  <= hd_addr;
                            mem_wdata <= hd.vk;
                            mem_len   <= access_len(1'b1, hd.op[2:0]);
                            state     <= ST_WAIT;
                        end else if (hd_load && (hd_addr[17:16] != IO_HI || hd.tag == rob_head)) begin
                            mem_req  <= 1'b1;
                            mem_wr   <= 1'b0;
                            mem_addr <= hd_addr;
                            mem_len  <= access_len(1'b0, hd.op[2:0]);
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (mem_done) begin
                        mem_req <= 1'b0;
                        state   <= ST_IDLE;
                        if (hd_load && !clear) begin
                            lsb_out_ok  <= 1'b1;
                            lsb_out_en  <= hd.tag;
                            lsb_out_val <= ext_data;
                        end
                    end else if (clear && hd_load) begin
                        state <= ST_DISCARD;
                    end
                end
                ST_DISCARD: begin
                    if (mem_done) begin
                        mem_req <= 1'b0;
                        state   <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsb.sv
// Scoreboard bench for lsb: stimulus queues expected memory requests and load
// results; a monitor pops and compares whenever the DUT presents one.
module tb_lsb;
    import lsb_pkg::*;

    logic             clk = 1'b0;
    logic             rst, rdy, clear, from_dc_ok;
    logic [5:0]       dc_opt;
    logic [ROB_W-1:0] dc_Qj, dc_Qk, dc_rob_en;
    logic             dc_Qj_ok, dc_Qk_ok;
    logic [31:0]      dc_Vj, dc_Vk, dc_imm;
    logic             is_lsb_full;
    logic             rob_commit;
    logic [ROB_W-1:0] rob_commit_pos, rob_head;
    logic             CDB_1_ok, CDB_2_ok;
    logic [ROB_W-1:0] CDB_1_en, CDB_2_en;
    logic [31:0]      CDB_1_val, CDB_2_val;
    logic             mem_req, mem_wr, mem_done;
    logic [31:0]      mem_addr, mem_wdata, mem_rdata;
    logic [1:0]       mem_len;
    logic             lsb_out_ok;
    logic [ROB_W-1:0] lsb_out_en;
    logic [31:0]      lsb_out_val;

    always #5 clk = ~clk;

    lsb dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear), .from_dc_ok(from_dc_ok),
        .dc_opt(dc_opt), .dc_Qj(dc_Qj), .dc_Qj_ok(dc_Qj_ok), .dc_Vj(dc_Vj),
        .dc_Qk(dc_Qk), .dc_Qk_ok(dc_Qk_ok), .dc_Vk(dc_Vk), .dc_imm(dc_imm),
        .dc_rob_en(dc_rob_en), .is_lsb_full(is_lsb_full),
        .rob_commit(rob_commit), .rob_commit_pos(rob_commit_pos), .rob_head(rob_head),
        .CDB_1_ok(CDB_1_ok), .CDB_1_en(CDB_1_en), .CDB_1_val(CDB_1_val),
        .CDB_2_ok(CDB_2_ok), .CDB_2_en(CDB_2_en), .CDB_2_val(CDB_2_val),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_len(mem_len), .mem_done(mem_done), .mem_rdata(mem_rdata),
        .lsb_out_ok(lsb_out_ok), .lsb_out_en(lsb_out_en), .lsb_out_val(lsb_out_val)
    );

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  len;
    } mem_exp_t;

    typedef struct {
        logic [ROB_W-1:0] en;
        logic [31:0]      val;
    } res_exp_t;

    mem_exp_t    exp_mem[$];
    res_exp_t    exp_res[$];
    logic [31:0] rdata_q[$];
    int          n_tests   = 0;
    int          n_fail    = 0;
    int          n_results = 0;
    int          mem_lat   = 2;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic exp_write(input logic [31:0] addr, input logic [31:0] data, input logic [1:0] len);
        mem_exp_t e;
        e = '{1'b1, addr, data, len};
        exp_mem.push_back(e);
    endtask

    task automatic exp_read(input logic [31:0] addr, input logic [1:0] len, input logic [31:0] rdata);
        mem_exp_t e;
        e = '{1'b0, addr, 32'h0, len};
        exp_mem.push_back(e);
        rdata_q.push_back(rdata);
    endtask

    task automatic exp_result(input logic [ROB_W-1:0] tag, input logic [31:0] val);
        res_exp_t r;
        r = '{tag, val};
        exp_res.push_back(r);
    endtask

    // Memory model: answers each request after mem_lat cycles with a one-cycle mem_done.
    initial begin : responder
        mem_done  = 1'b0;
        mem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req === 1'b1 && !rst) begin
                repeat (mem_lat - 1) @(negedge clk);
                mem_rdata = (rdata_q.size() != 0) ? rdata_q.pop_front() : 32'h0;
                mem_done  = 1'b1;
                @(negedge clk);
                mem_done  = 1'b0;
            end
        end
    end

    initial begin : monitor
        logic     prev_req;
        mem_exp_t cur, e;
        res_exp_t r;
        prev_req = 1'b0;
        cur      = '{1'b0, 32'h0, 32'h0, 2'd0};
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mem_req && !prev_req) begin
                    if (exp_mem.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_mem_req: addr 0x%08h wr %0b, none expected", mem_addr, mem_wr);
                    end else begin
                        e = exp_mem.pop_front();
                        check("mem_wr", 32'(mem_wr), 32'(e.wr));
                        check("mem_addr", mem_addr, e.addr);
                        check("mem_len", 32'(mem_len), 32'(e.len));
                        if (e.wr)
                            check("mem_wdata", mem_wdata, e.wdata);
                    end
                    cur = '{mem_wr, mem_addr, mem_wdata, mem_len};
                end else if (mem_req && prev_req) begin
                    check("mem_addr_hold", mem_addr, cur.addr);
                end
                if (lsb_out_ok) begin
                    n_results++;
                    if (exp_res.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL unexpected_result: tag %0d val 0x%08h, none expected", lsb_out_en, lsb_out_val);
                    end else begin
                        r = exp_res.pop_front();
                        check("out_en", 32'(lsb_out_en), 32'(r.en));
                        check("out_val", lsb_out_val, r.val);
                    end
                end
            end
            prev_req = mem_req;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [5:0] opt, input logic [ROB_W-1:0] qj, input logic qj_ok,
                         input logic [31:0] vj, input logic [31:0] vk, input logic [31:0] imm,
                         input logic [ROB_W-1:0] tag);
        dc_opt     = opt;
        dc_Qj      = qj;
        dc_Qj_ok   = qj_ok;
        dc_Vj      = vj;
        dc_Qk      = '0;
        dc_Qk_ok   = 1'b1;
        dc_Vk      = vk;
        dc_imm     = imm;
        dc_rob_en  = tag;
        from_dc_ok = 1'b1;
        @(negedge clk);
        from_dc_ok = 1'b0;
    endtask

    task automatic commit(input logic [ROB_W-1:0] tag);
        rob_commit     = 1'b1;
        rob_commit_pos = tag;
        @(negedge clk);
        rob_commit     = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic no_req(input int cycles, input string name);
        int hi = 0;
        repeat (cycles) begin
            @(negedge clk);
            if (mem_req) hi++;
        end
        check(name, 32'(hi), 32'd0);
    endtask

    task automatic wait_req(input string name);
        int t = 0;
        while (mem_req !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check({name, "_req_seen"}, 32'(mem_req), 32'd1);
    endtask

    task automatic wait_drain(input string name);
        int t = 0;
        while ((exp_mem.size() != 0 || exp_res.size() != 0 || dut.count != 0 || mem_req) && t < 300) begin
            @(negedge clk);
            t++;
        end
        check({name, "_drained"}, 32'(t < 300), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    initial begin : stimulus
        int r0, t;
        rst = 1'b1; rdy = 1'b1; clear = 1'b0; from_dc_ok = 1'b0;
        dc_opt = '0; dc_Qj = '0; dc_Qj_ok = 1'b0; dc_Vj = '0; dc_Qk = '0; dc_Qk_ok = 1'b0;
        dc_Vk = '0; dc_imm = '0; dc_rob_en = '0;
        rob_commit = 1'b0; rob_commit_pos = '0; rob_head = '0;
        CDB_1_ok = 1'b0; CDB_1_en = '0; CDB_1_val = '0;
        CDB_2_ok = 1'b0; CDB_2_en = '0; CDB_2_val = '0;

        repeat (3) @(negedge clk);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_out_ok", 32'(lsb_out_ok), 32'd0);
        check("rst_full", 32'(is_lsb_full), 32'd0);
        check("rst_count", 32'(dut.count), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Store waits for commit, then writes Vj+imm.
        exp_write(32'h104, 32'hDEADBEEF, 2'd2);
        issue({OPC_STORE, F3_SW}, '0, 1'b1, 32'h100, 32'hDEADBEEF, 32'h4, 4'd1);
        no_req(10, "sw_uncommitted_stall");
        commit(4'd1);
        wait_drain("sw");

        // Loads with the base pending on a CDB; extension by funct3.
        exp_read(32'h210, 2'd0, 32'h80);
        exp_result(4'd2, 32'hFFFFFF80);
        issue({OPC_LOAD, F3_LB}, 4'd3, 1'b0, 32'h0, 32'h0, 32'h10, 4'd2);
        no_req(3, "lb_qj_stall");
        CDB_1_ok = 1'b1; CDB_1_en = 4'd3; CDB_1_val = 32'h200;
        @(negedge clk);
        CDB_1_ok = 1'b0;
        wait_drain("lb");

        exp_read(32'h210, 2'd0, 32'h80);
        exp_result(4'd4, 32'h00000080);
        issue({OPC_LOAD, F3_LBU}, 4'd3, 1'b0, 32'h0, 32'h0, 32'h10, 4'd4);
        CDB_1_ok = 1'b1; CDB_1_en = 4'd3; CDB_1_val = 32'h200;
        @(negedge clk);
        CDB_1_ok = 1'b0;
        wait_drain("lbu");

        exp_read(32'h2FC, 2'd1, 32'hABCD8001);
        exp_result(4'd5, 32'hFFFF8001);
        issue({OPC_LOAD, F3_LH}, 4'd6, 1'b0, 32'h0, 32'h0, 32'hFFFFFFFC, 4'd5);
        CDB_2_ok = 1'b1; CDB_2_en = 4'd6; CDB_2_val = 32'h300;
        @(negedge clk);
        CDB_2_ok = 1'b0;
        wait_drain("lh");

        exp_read(32'h2FC, 2'd1, 32'hABCD8001);
        exp_result(4'd6, 32'h00008001);
        issue({OPC_LOAD, F3_LHU}, 4'd7, 1'b0, 32'h0, 32'h0, 32'hFFFFFFFC, 4'd6);
        CDB_2_ok = 1'b1; CDB_2_en = 4'd7; CDB_2_val = 32'h300;
        @(negedge clk);
        CDB_2_ok = 1'b0;
        wait_drain("lhu");

        // Operand broadcast in the issue cycle itself is captured.
        exp_read(32'h48, 2'd2, 32'h12345678);
        exp_result(4'd7, 32'h12345678);
        CDB_1_ok = 1'b1; CDB_1_en = 4'd8; CDB_1_val = 32'h40;
        issue({OPC_LOAD, F3_LW}, 4'd8, 1'b0, 32'h0, 32'h0, 32'h8, 4'd7);
        CDB_1_ok = 1'b0;
        wait_drain("lw_issue_capture");

        // Clear while a committed store is in flight: store completes, load dropped.
        mem_lat = 4;
        exp_write(32'h500, 32'h11, 2'd2);
        issue({OPC_STORE, F3_SW}, '0, 1'b1, 32'h500, 32'h11, 32'h0, 4'd1);
        issue({OPC_LOAD, F3_LW}, '0, 1'b1, 32'h600, 32'h0, 32'h0, 4'd2);
        no_req(3, "st_ld_uncommitted_stall");
        commit(4'd1);
        wait_req("st_clr");
        do_clear();
        check("st_clr_count_kept", 32'(dut.count), 32'd1);
        wait_drain("st_clr");
        no_req(5, "st_clr_load_dropped");

        // Clear while a load waits on memory: no result.
        r0 = n_results;
        exp_read(32'h700, 2'd2, 32'h55);
        issue({OPC_LOAD, F3_LW}, '0, 1'b1, 32'h700, 32'h0, 32'h0, 4'd3);
        wait_req("ld_clr");
        do_clear();
        wait_drain("ld_clr");
        check("ld_clr_no_result", 32'(n_results - r0), 32'd0);

        // Clear in the same cycle as mem_done of a load.
        mem_lat = 1;
        r0 = n_results;
        exp_read(32'h704, 2'd2, 32'h66);
        issue({OPC_LOAD, F3_LW}, '0, 1'b1, 32'h704, 32'h0, 32'h0, 4'd4);
        wait_req("ld_clr_done");
        do_clear();
        wait_drain("ld_clr_done");
        check("ld_clr_done_no_result", 32'(n_results - r0), 32'd0);
        check("ld_clr_done_count", 32'(dut.count), 32'd0);

        // I/O load is not speculative: waits for rob_head.
        mem_lat = 2;
        exp_read(32'h30000, 2'd2, 32'hCAFE0000);
        exp_result(4'd5, 32'hCAFE0000);
        issue({OPC_LOAD, F3_LW}, '0, 1'b1, 32'h30000, 32'h0, 32'h0, 4'd5);
        no_req(5, "io_spec_stall");
        rob_head = 4'd5;
        @(negedge clk);
        check("io_req_next_cycle", 32'(mem_req), 32'd1);
        wait_drain("io");
        rob_head = '0;

        // Fill to LSB_LEN-1, pop one, refill; second round wraps head/tail.
        for (int i = 0; i < 15; i++) begin
            exp_write(32'h1000 + 32'(4 * i), 32'(i), 2'd2);
            issue({OPC_STORE, F3_SW}, '0, 1'b1, 32'h1000 + 32'(4 * i), 32'(i), 32'h0, 4'(i));
            if (i == 13)
                check("full_at_14", 32'(is_lsb_full), 32'd0);
        end
        check("full_at_15", 32'(is_lsb_full), 32'd1);
        commit(4'd0);
        t = 0;
        while (dut.count != 14 && t < 50) begin
            @(negedge clk);
            t++;
        end
        check("full_after_pop", 32'(is_lsb_full), 32'd0);
        exp_write(32'h103C, 32'd15, 2'd2);
        issue({OPC_STORE, F3_SW}, '0, 1'b1, 32'h103C, 32'd15, 32'h0, 4'd15);
        check("full_refill", 32'(is_lsb_full), 32'd1);
        for (int i = 1; i < 16; i++)
            commit(4'(i));
        wait_drain("fill1");

        for (int i = 0; i < 15; i++) begin
            exp_write(32'h2000 + 32'(4 * i), 32'h100 + 32'(i), 2'd1);
            issue({OPC_STORE, F3_SH}, '0, 1'b1, 32'h2000 + 32'(4 * i), 32'h100 + 32'(i), 32'h0, 4'(i));
        end
        check("full_wrap", 32'(is_lsb_full), 32'd1);
        for (int i = 0; i < 15; i++)
            commit(4'(i));
        wait_drain("fill2");
        check("empty_not_full", 32'(is_lsb_full), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
